// File: rtl/alu_pkg.sv
// Shared ALU op-code table and execution-unit state encoding; the ALU control
// decoder imports the same table so both ends agree on every code.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1110;
  localparam logic [3:0] ALU_JR  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_known_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_ADD, ALU_SUB, ALU_SLT,
      ALU_NOR, ALU_SLL, ALU_JR: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle left shifter with a down-counter; o_done is high in the
// cycle whose clock edge performs the final shift, and o_data is that value.
module alu_serial_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_amt,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_data
);

  logic [WIDTH-1:0]   r_sreg;
  logic [SHAMT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_sreg <= i_data;
      r_cnt  <= i_amt;
    end else if (r_cnt != '0) begin
      r_sreg <= r_sreg << 1;
      r_cnt  <= r_cnt - SHAMT_W'(1);
    end
  end

  // Look-ahead so the owner can capture the last shift on the same edge.
  assign o_done = (r_cnt == SHAMT_W'(1));
  assign o_data = r_sreg << 1;

endmodule

// File: rtl/alu_exec_unit.sv
// MIPS ALU execution unit: single-cycle ops register in 1 cycle, SLL takes shamt+1;
// result is held with out_valid until out_ready, and no new op is taken until then.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_control,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal
);

  alu_state_e       r_state;
  alu_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;
  logic             r_illegal;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_op_res;
  logic             w_op_ovf;
  logic             w_op_ill;

  logic             w_res_ld;
  logic [WIDTH-1:0] w_res_val;
  logic             w_ovf_val;
  logic             w_ill_val;
  logic             w_shift_ld;
  logic             w_shift_done;
  logic [WIDTH-1:0] w_shift_dat;

  assign w_sum    = operand_a + operand_b;
  assign w_diff   = operand_a - operand_b;
  assign w_slt    = $signed(operand_a) < $signed(operand_b);
  assign w_op_ill = ~is_known_op(alu_control);

  // SLL here covers only shamt==0; non-zero amounts go through the serial shifter.
  always_comb begin
    w_op_res = '0;
    w_op_ovf = 1'b0;
    case (alu_control)
      ALU_AND: w_op_res = operand_a & operand_b;
      ALU_ADD: begin
        w_op_res = w_sum;
        w_op_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_op_res = w_diff;
        w_op_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                   (w_diff[WIDTH-1] != operand_a[WIDTH-1]);
      end
      ALU_SLT: w_op_res = {{(WIDTH-1){1'b0}}, w_slt};
      ALU_NOR: w_op_res = ~(operand_a | operand_b);
      ALU_SLL: w_op_res = operand_b;
      ALU_JR:  w_op_res = operand_a;
      default: w_op_res = '0;
    endcase
  end

  alu_serial_shifter #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .i_load(w_shift_ld),
    .i_data(operand_b),
    .i_amt (shamt),
    .o_done(w_shift_done),
    .o_data(w_shift_dat)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_res_ld    = 1'b0;
    w_res_val   = '0;
    w_ovf_val   = 1'b0;
    w_ill_val   = 1'b0;
    w_shift_ld  = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (alu_control == ALU_SLL && shamt != '0) begin
            w_shift_ld  = 1'b1;
            w_state_nxt = SHIFT;
          end else begin
            w_res_ld    = 1'b1;
            w_res_val   = w_op_res;
            w_ovf_val   = w_op_ovf;
            w_ill_val   = w_op_ill;
            w_state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        if (w_shift_done) begin
          w_res_ld    = 1'b1;
          w_res_val   = w_shift_dat;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Flags move only together with a new result so they always describe it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_res_ld) begin
        r_result   <= w_res_val;
        r_zero     <= (w_res_val == '0);
        r_overflow <= w_ovf_val;
        r_illegal  <= w_ill_val;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        ill;
  } exp_t;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .shamt      (shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model from the op table using plain wide-integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
    exp_t   e;
    longint sa, sb, r;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    e  = '0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0010: begin
        r = sa + sb;
        e.res = 32'(r);
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'b0110: begin
        r = sa - sb;
        e.res = 32'(r);
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: e.res = ~(a | b);
      4'b1110: e.res = 32'(64'(b) * (64'd1 << sh));
      4'b1111: e.res = a;
      default: begin
        e.res = 32'd0;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input int hold);
    exp_t e;
    int   lat;
    int   exp_lat;
    bit   busy_ok;
    bit   stable;
    e       = model(op, a, b, sh);
    exp_lat = (op == 4'b1110 && sh != 5'd0) ? int'(sh) + 1 : 1;
    chk({tag, ":idle_ready"}, {31'd0, in_ready}, 32'd1);
    alu_control = op;
    operand_a   = a;
    operand_b   = b;
    shamt       = sh;
    in_valid    = 1'b1;
    tick();
    // Keep offering junk while busy; none of it may be taken.
    alu_control = 4'($urandom);
    operand_a   = $urandom;
    operand_b   = $urandom;
    shamt       = 5'($urandom);
    lat         = 1;
    busy_ok     = 1'b1;
    while (out_valid !== 1'b1 && lat < 64) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      tick();
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":busy_not_ready"}, {31'd0, busy_ok}, 32'd1);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.res) stable = 1'b0;
    end
    chk({tag, ":hold_stable"}, {31'd0, stable}, 32'd1);
    chk({tag, ":result"}, result, e.res);
    chk({tag, ":zero"}, {31'd0, zero}, {31'd0, (e.res == 32'd0)});
    chk({tag, ":overflow"}, {31'd0, overflow}, {31'd0, e.ovf});
    chk({tag, ":illegal"}, {31'd0, illegal}, {31'd0, e.ill});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ":drop_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ":back_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ":result_kept"}, result, e.res);
  endtask

  initial begin
    bit          late;
    logic [3:0]  op;
    logic [31:0] a, b;
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_control = 4'd0;
    operand_a   = 32'd0;
    operand_b   = 32'd0;
    shamt       = 5'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset:in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset:out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset:result", result, 32'd0);
    chk("reset:zero", {31'd0, zero}, 32'd0);
    chk("reset:overflow", {31'd0, overflow}, 32'd0);
    chk("reset:illegal", {31'd0, illegal}, 32'd0);

    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0);
    chk("add_ovf:value", result, 32'h8000_0000);
    run_op("sub_zero", 4'b0110, 32'h1234_5678, 32'h1234_5678, 5'd0, 0);
    run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd0, 1);
    run_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0);
    chk("slt_neg:value", result, 32'd1);
    run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd7, 0);
    run_op("sll4", 4'b1110, 32'hDEAD_BEEF, 32'h0000_0003, 5'd4, 0);
    chk("sll4:value", result, 32'h0000_0030);
    run_op("sll0", 4'b1110, 32'h0, 32'hCAFE_F00D, 5'd0, 0);
    run_op("sll31", 4'b1110, 32'h0, 32'h0000_0003, 5'd31, 0);
    run_op("nor_bp", 4'b1100, 32'h0, 32'h0, 5'd0, 10);
    chk("nor_bp:value", result, 32'hFFFF_FFFF);
    run_op("after_bp", 4'b0010, 32'h0000_0005, 32'h0000_0007, 5'd0, 0);
    run_op("illegal", 4'b0101, 32'h1111_1111, 32'h2222_2222, 5'd0, 0);
    run_op("jr", 4'b1111, 32'h0040_0020, 32'h0000_0000, 5'd0, 0);
    chk("jr:value", result, 32'h0040_0020);

    // Reset in the tenth shift cycle must discard the shift completely.
    alu_control = 4'b1110;
    operand_b   = 32'h0000_0001;
    shamt       = 5'd31;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("rst_shift:busy", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    tick();
    chk("rst_shift:out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_shift:result", result, 32'd0);
    chk("rst_shift:in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_shift:zero", {31'd0, zero}, 32'd0);
    reset = 1'b0;
    late  = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid !== 1'b0) late = 1'b1;
    end
    chk("rst_shift:no_late_result", {31'd0, late}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
      a  = (i % 7 == 0) ? 32'h7FFF_FFFF : $urandom;
      b  = (i % 5 == 0) ? a : $urandom;
      run_op($sformatf("rand%0d", i), op, a, b, 5'($urandom_range(0, 31)),
             int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
